// File: rtl/booth8_sequencer_if.sv
// Host/datapath-facing bundle of the radix-8 Booth sequencer: Start and the Booth window in,
// register enables, mux controls, Busy and the Done pulse out.
interface booth8_sequencer_if;
   logic       Start;
   logic [3:0] Q_Bits;
   logic       A_En;
   logic       B_En;
   logic       C_En;
   logic       Load;
   logic       Pre3M;
   logic [2:0] Mult_Sel;
   logic       Mult_Neg;
   logic       Shift;
   logic       Busy;
   logic       Done;

   modport master (
      output Start, Q_Bits,
      input  A_En, B_En, C_En, Load, Pre3M, Mult_Sel, Mult_Neg, Shift, Busy, Done
   );

   modport slave (
      input  Start, Q_Bits,
      output A_En, B_En, C_En, Load, Pre3M, Mult_Sel, Mult_Neg, Shift, Busy, Done
   );
endinterface

// File: rtl/booth8_sequencer.sv
// Radix-8 Booth control FSM: fixed latency, Done in cycle k+3+2*ITER after Start sampled at edge k.
// No backpressure; Start is only looked at in IDLE and is dropped otherwise.
module booth8_sequencer #(
   parameter int N = 8
) (
   input  logic                Clock,
   input  logic                Reset_n,
   booth8_sequencer_if.slave   bus
);
   localparam int ITER = (N + 3) / 3;
   localparam int CW   = $clog2(ITER + 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      PRE   = 3'd2,
      ADD   = 3'd3,
      SHIFT = 3'd4,
      DONE  = 3'd5
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;

   // Returns {neg, sel}; the all-ones window maps to +0 so negative zero never appears.
   function automatic logic [3:0] recode(input logic [3:0] q);
      case (q)
         4'b0001, 4'b0010: return {1'b0, 3'd1};
         4'b0011, 4'b0100: return {1'b0, 3'd2};
         4'b0101, 4'b0110: return {1'b0, 3'd3};
         4'b0111:          return {1'b0, 3'd4};
         4'b1000:          return {1'b1, 3'd4};
         4'b1001, 4'b1010: return {1'b1, 3'd3};
         4'b1011, 4'b1100: return {1'b1, 3'd2};
         4'b1101, 4'b1110: return {1'b1, 3'd1};
         default:          return {1'b0, 3'd0};
      endcase
   endfunction

   always_ff @(posedge Clock) begin
      if (!Reset_n) begin
         state        <= IDLE;
         cnt          <= '0;
         bus.A_En     <= 1'b0;
         bus.B_En     <= 1'b0;
         bus.C_En     <= 1'b0;
         bus.Load     <= 1'b0;
         bus.Pre3M    <= 1'b0;
         bus.Mult_Sel <= 3'd0;
         bus.Mult_Neg <= 1'b0;
         bus.Shift    <= 1'b0;
         bus.Busy     <= 1'b0;
         bus.Done     <= 1'b0;
      end else begin
         // Outputs are decoded from the state being entered, so they line up with it.
         bus.A_En     <= 1'b0;
         bus.B_En     <= 1'b0;
         bus.C_En     <= 1'b0;
         bus.Load     <= 1'b0;
         bus.Pre3M    <= 1'b0;
         bus.Mult_Sel <= 3'd0;
         bus.Mult_Neg <= 1'b0;
         bus.Shift    <= 1'b0;
         bus.Busy     <= 1'b0;
         bus.Done     <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.Start) begin
                  state    <= LOAD;
                  bus.Load <= 1'b1;
                  bus.A_En <= 1'b1;
                  bus.B_En <= 1'b1;
                  bus.Busy <= 1'b1;
               end
            end
            LOAD: begin
               state     <= PRE;
               cnt       <= CW'(ITER);
               bus.Pre3M <= 1'b1;
               bus.C_En  <= 1'b1;
               bus.Busy  <= 1'b1;
            end
            PRE: begin
               state    <= ADD;
               bus.A_En <= 1'b1;
               bus.Busy <= 1'b1;
               {bus.Mult_Neg, bus.Mult_Sel} <= recode(bus.Q_Bits);
            end
            ADD: begin
               state     <= SHIFT;
               bus.Shift <= 1'b1;
               bus.A_En  <= 1'b1;
               bus.B_En  <= 1'b1;
               bus.Busy  <= 1'b1;
            end
            SHIFT: begin
               cnt      <= (cnt == '0) ? '0 : cnt - 1'b1;
               bus.Busy <= 1'b1;
               // Treating a zero count like the last pass keeps the loop from ever wrapping.
               if (cnt <= CW'(1)) begin
                  state    <= DONE;
                  bus.Done <= 1'b1;
               end else begin
                  state    <= ADD;
                  bus.A_En <= 1'b1;
                  {bus.Mult_Neg, bus.Mult_Sel} <= recode(bus.Q_Bits);
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end
endmodule
